mem_port_arbiter: RTL and testbench

- Shares the single-port data/instruction memory between two requesters: the CPU control FSM (read/write) and the debug/infer display reader (read-only).
- Sits between both requesters and the memory's en/ren/wen/addr/din/dout pins.
- Replaces the ad-hoc wait states the control FSM uses today with a request/grant protocol and a fixed, parameterised read latency.
- CPU has priority; a starvation limit guarantees the debug reader service.

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 78 +++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU, debug and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en, mem_ren, mem_wen, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_en, mem_ren, mem_wen, mem_addr, mem_din, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_en, mem_ren, mem_wen, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority arbiter for a single-port memory with fixed read latency
// and a starvation limit that guarantees the debug reader service.
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int READ_LAT       = 2,
  parameter int DBG_STARVE_MAX = 8
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t            state, state_next;
  logic [3:0]        wait_cnt;
  logic [7:0]        starve_cnt;
  logic              owner;
  logic              can_grant, grant_cpu, grant_dbg, rd_req, rd_done;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] rd_data;
  // the write strobe cycle blocks a new grant, giving one write per two cycles
  always_comb begin
    can_grant  = state == IDLE && !bus.mem_wen;
    grant_cpu  = can_grant && bus.cpu_req && (!bus.dbg_req || starve_cnt != 8'(DBG_STARVE_MAX));
    grant_dbg  = can_grant && bus.dbg_req && !grant_cpu;
    rd_req     = grant_dbg || (grant_cpu && !bus.cpu_we);
    rd_done    = state == RD_WAIT && wait_cnt == 4'd1;
    win_addr   = grant_cpu ? bus.cpu_addr : bus.dbg_addr;
    rd_data    = bus.mem_dout;
    state_next = rd_req ? RD_WAIT : rd_done ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt       <= '0;
      starve_cnt     <= '0;
      owner          <= 1'b0;
      bus.cpu_gnt    <= 1'b0;
      bus.dbg_gnt    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.dbg_rdata  <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_ren    <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.cpu_gnt    <= grant_cpu;
      bus.dbg_gnt    <= grant_dbg;
      bus.cpu_rvalid <= rd_done && !owner;
      bus.dbg_rvalid <= rd_done && owner;
      bus.busy       <= state_next == RD_WAIT;
      bus.mem_wen    <= grant_cpu && bus.cpu_we;
      if (rd_done && !owner) bus.cpu_rdata <= rd_data;
      if (rd_done && owner) bus.dbg_rdata <= rd_data;
      if (grant_cpu || grant_dbg) begin
        bus.mem_en   <= 1'b1;
        bus.mem_ren  <= rd_req;
        bus.mem_addr <= win_addr;
        owner        <= grant_dbg;
        wait_cnt     <= 4'(READ_LAT);
      end else if (state == IDLE || rd_done) begin
        bus.mem_en  <= 1'b0;
        bus.mem_ren <= 1'b0;
      end
      if (state == RD_WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (grant_cpu && bus.cpu_we) bus.mem_din <= bus.cpu_wdata;
      if (state == IDLE)
        starve_cnt <= (grant_dbg || !bus.dbg_req) ? 8'd0 :
                      (grant_cpu && starve_cnt != 8'(DBG_STARVE_MAX)) ? starve_cnt + 8'd1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven transactions plus hand-written sequences for
// starvation, mid-read requests, asynchronous reset and single-cycle read latency.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b1 ();
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(2), .DBG_STARVE_MAX(8))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(1), .DBG_STARVE_MAX(8))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  logic [31:0] mem0 [0:65535];
  always @(posedge clk)
    if (reset) mem0[16'h0010] <= 32'hDEADBEEF;
    else if (b0.mem_en && b0.mem_wen) mem0[b0.mem_addr] <= b0.mem_din;
  assign b0.mem_dout = mem0[b0.mem_addr];
  assign b1.mem_dout = {16'hC0DE, b1.mem_addr};
  typedef struct {
    bit          dbg;
    bit          we;
    logic [15:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [6];
  int pass_n = 0;
  int total_n = 0;
  logic [31:0] cpu_model = '0;
  logic [31:0] dbg_model = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, 32'({b0.cpu_gnt, b0.cpu_rvalid, b0.dbg_gnt, b0.dbg_rvalid,
                               b0.mem_en, b0.mem_ren, b0.mem_wen, b0.busy}), 32'd0);
    chk({name, "_cpu_rdata"}, b0.cpu_rdata, 32'd0);
    chk({name, "_dbg_rdata"}, b0.dbg_rdata, 32'd0);
    chk({name, "_addr_din"}, {16'(b0.mem_addr), 16'd0} | b0.mem_din, 32'd0);
  endtask
  task automatic xact(input vec_t v);
    int n, en_n, busy_n, other_rv, addr_bad;
    b0.cpu_we = v.we;
    b0.cpu_addr = v.addr;
    b0.cpu_wdata = v.data;
    b0.dbg_addr = v.addr;
    if (v.dbg) b0.dbg_req = 1'b1;
    else b0.cpu_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(v.dbg ? b0.dbg_gnt : b0.cpu_gnt) && n < 20);
    b0.cpu_req = 1'b0;
    b0.dbg_req = 1'b0;
    chk("gnt", 32'(v.dbg ? b0.dbg_gnt : b0.cpu_gnt), 32'd1);
    chk("gnt_other", 32'(v.dbg ? b0.cpu_gnt : b0.dbg_gnt), 32'd0);
    chk("strobes", 32'({b0.mem_en, b0.mem_ren, b0.mem_wen}), 32'({1'b1, !v.we, v.we}));
    chk("mem_addr", 32'(b0.mem_addr), 32'(v.addr));
    if (v.we) begin
      chk("mem_din", b0.mem_din, v.data);
      tick();
      chk("wen_one_cycle", 32'({b0.mem_en, b0.mem_wen}), 32'd0);
      chk("wr_no_rvalid", 32'({b0.cpu_rvalid, b0.dbg_rvalid}), 32'd0);
    end else begin
      n = 0; en_n = 0; busy_n = 0; other_rv = 0; addr_bad = 0;
      while (!(v.dbg ? b0.dbg_rvalid : b0.cpu_rvalid) && n < 20) begin
        if (b0.mem_en && b0.mem_ren) en_n++;
        if (b0.busy) busy_n++;
        if (b0.mem_addr != v.addr) addr_bad++;
        tick();
        n++;
        if (v.dbg ? b0.cpu_rvalid : b0.dbg_rvalid) other_rv++;
      end
      chk("rd_latency", 32'(n), 32'd2);
      chk("en_ren_cycles", 32'(en_n), 32'd2);
      chk("busy_cycles", 32'(busy_n), 32'd2);
      chk("addr_held", 32'(addr_bad), 32'd0);
      chk("other_rvalid", 32'(other_rv), 32'd0);
      chk("en_off_at_rvalid", 32'({b0.mem_en, b0.mem_ren, b0.busy}), 32'd0);
      if (v.dbg) dbg_model = v.data;
      else cpu_model = v.data;
    end
    chk("cpu_rdata", b0.cpu_rdata, cpu_model);
    chk("dbg_rdata", b0.dbg_rdata, dbg_model);
  endtask
  initial begin
    logic [17:0] seq;
    int n, g, ov, rvov, c, rv_at, g_at, cyc, gi, ri, last_g;
    logic [15:0] ga;
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 16'h189C, 32'h12345678};
    tbl[2] = '{1'b1, 1'b0, 16'h189C, 32'h12345678};
    tbl[3] = '{1'b0, 1'b1, 16'h0020, 32'h000000A5};
    tbl[4] = '{1'b0, 1'b0, 16'h0020, 32'h000000A5};
    tbl[5] = '{1'b1, 1'b0, 16'h0010, 32'hDEADBEEF};
    {b0.cpu_req, b0.cpu_we, b0.dbg_req, b1.cpu_req, b1.cpu_we, b1.dbg_req} = '0;
    {b0.cpu_addr, b0.dbg_addr, b1.cpu_addr, b1.dbg_addr} = '0;
    {b0.cpu_wdata, b1.cpu_wdata} = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero("reset");
    for (int i = 0; i < 6; i++) xact(tbl[i]);
    // both requesters held high: 8 CPU grants then one debug grant, twice
    b0.cpu_we = 1'b0;
    b0.cpu_addr = 16'h0010;
    b0.dbg_addr = 16'h189C;
    b0.cpu_req = 1'b1;
    b0.dbg_req = 1'b1;
    seq = '0; g = 0; ov = 0; rvov = 0; n = 0;
    while (g < 18 && n < 200) begin
      tick();
      n++;
      if (b0.cpu_gnt && b0.dbg_gnt) ov++;
      if (b0.cpu_rvalid && b0.dbg_rvalid) rvov++;
      if (b0.cpu_gnt || b0.dbg_gnt) begin
        seq[g] = b0.dbg_gnt;
        g++;
      end
    end
    b0.cpu_req = 1'b0;
    b0.dbg_req = 1'b0;
    chk("starve_grants", 32'(g), 32'd18);
    chk("starve_seq", 32'(seq), 32'h0002_0100);
    chk("gnt_overlap", 32'(ov), 32'd0);
    n = 0;
    while (b0.busy && n < 10) begin
      tick();
      n++;
      if (b0.cpu_rvalid && b0.dbg_rvalid) rvov++;
    end
    chk("rvalid_overlap", 32'(rvov), 32'd0);
    cpu_model = 32'hDEADBEEF;
    dbg_model = 32'h12345678;
    chk("starve_cpu_rdata", b0.cpu_rdata, cpu_model);
    chk("starve_dbg_rdata", b0.dbg_rdata, dbg_model);
    // CPU request raised while a debug read is in flight
    b0.dbg_addr = 16'h0010;
    b0.dbg_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!b0.dbg_gnt && n < 10);
    b0.dbg_req = 1'b0;
    chk("mid_dbg_gnt", 32'(b0.dbg_gnt), 32'd1);
    tick();
    b0.cpu_we = 1'b0;
    b0.cpu_addr = 16'h0020;
    b0.cpu_req = 1'b1;
    c = 1; rv_at = -1; g_at = -1;
    while (!b0.cpu_rvalid && c < 20) begin
      tick();
      c++;
      if (b0.dbg_rvalid) rv_at = c;
      if (b0.cpu_gnt && g_at < 0) begin
        g_at = c;
        b0.cpu_req = 1'b0;
      end
    end
    b0.cpu_req = 1'b0;
    chk("mid_dbg_rvalid_at", 32'(rv_at), 32'd2);
    chk("mid_cpu_gnt_at", 32'(g_at), 32'd3);
    chk("mid_cpu_rvalid_at", 32'(c), 32'd5);
    chk("mid_cpu_rdata", b0.cpu_rdata, 32'h000000A5);
    chk("mid_dbg_rdata", b0.dbg_rdata, 32'hDEADBEEF);
    // asynchronous reset one cycle into a read
    b0.cpu_addr = 16'h0010;
    b0.cpu_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!b0.cpu_gnt && n < 10);
    b0.cpu_req = 1'b0;
    chk("rst_pre_gnt", 32'(b0.cpu_gnt), 32'd1);
    tick();
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    tick();
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b0.cpu_rvalid || b0.dbg_rvalid || b0.busy) n++;
    end
    chk("no_rvalid_after_reset", 32'(n), 32'd0);
    cpu_model = '0;
    dbg_model = '0;
    xact(tbl[4]);
    // READ_LAT = 1 instance, back-to-back CPU reads with the request held high
    b1.cpu_we = 1'b0;
    b1.cpu_addr = 16'h0100;
    b1.cpu_req = 1'b1;
    cyc = 0; gi = 0; ri = 0; last_g = -10; ga = '0;
    while (ri < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (b1.cpu_rvalid) begin
        chk("l1_latency", 32'(cyc - last_g), 32'd1);
        chk("l1_rdata", b1.cpu_rdata, {16'hC0DE, ga});
        ri++;
      end
      if (b1.cpu_gnt) begin
        if (gi > 0) chk("l1_spacing", 32'(cyc - last_g), 32'd2);
        last_g = cyc;
        ga = 16'h0100 + 16'(gi);
        gi++;
        b1.cpu_addr = 16'h0100 + 16'(gi);
        if (gi == 4) b1.cpu_req = 1'b0;
      end
    end
    b1.cpu_req = 1'b0;
    chk("l1_reads", 32'(ri), 32'd4);
    chk("l1_dbg_rdata", b1.dbg_rdata, 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
